// File: rtl/reset_pkg.sv
// Shared definitions for the DCFEB reset sequencer: state encoding, request indices, helpers.
package reset_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MRST   = 3'd1,
    ST_LOCKW  = 3'd2,
    ST_SHOLD  = 3'd3,
    ST_ARST   = 3'd4,
    ST_AWAIT  = 3'd5,
    ST_FAILED = 3'd6
  } seq_state_e;

  localparam int unsigned REQ_JTAG = 0;
  localparam int unsigned REQ_CSP  = 1;
  localparam int unsigned REQ_QPLL = 2;
  localparam int unsigned REQ_MMCM = 3;
  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned CNT_W    = 20;

  // Isolates the lowest set bit, which is the highest-priority source.
  function automatic logic [NUM_REQ-1:0] lowest_one(input logic [NUM_REQ-1:0] v);
    return v & (~v + {{(NUM_REQ-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/rst_req_arb.sv
// Request capture: rising-edge detect into sticky pending bits, fixed-priority one-hot select.
// A grant clears its bit, but an edge on the same cycle re-arms it so it is served again.
module rst_req_arb
  import reset_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               take_i,
  output logic               any_pend_o,
  output logic [NUM_REQ-1:0] sel_o
);

  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] rise;

  assign rise       = req_i & ~req_q;
  assign sel_o      = lowest_one(pend_q);
  assign any_pend_o = |pend_q;

  always_comb begin
    pend_d = pend_q;
    if (take_i) pend_d = pend_d & ~sel_o;
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= '0;
      pend_q <= '0;
    end else begin
      req_q  <= req_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/reset_seq_ctrl.sv
// Reset sequencer: MMCM pulse, lock wait, system-reset hold, ADC-init reset and ready wait,
// each wait bounded by a timeout with retry; outputs are Moore and registered.
module reset_seq_ctrl
  import reset_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYC = 8,
  parameter int unsigned LOCK_TMO     = 4000,
  parameter int unsigned SYS_HOLD     = 32,
  parameter int unsigned ADC_TMO      = 400000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic         CLK,
  input  logic         EOS,
  input  logic [3:0]   REQ,
  input  logic         MMCM_LOCK,
  input  logic         ADC_RDY,
  output logic         MMCM_RST,
  output logic         SYS_RST,
  output logic         ADC_INIT_RST,
  output logic         BUSY,
  output logic [3:0]   GNT,
  output logic [1:0]   RETRY_CNT,
  output logic         FAIL,
  output logic [2:0]   SEQ_STATE
);

  localparam logic [CNT_W-1:0] MRST_LAST = CNT_W'(MMCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SYS_HOLD - 1);
  localparam logic [CNT_W-1:0] ADC_LAST  = CNT_W'(ADC_TMO - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       retry_q, retry_d, retry_inc;
  logic             mmcm_rst_q, sys_rst_q, adc_rst_q, busy_q, fail_q;
  logic             take, any_pend;
  logic [3:0]       sel;

  rst_req_arb u_arb (
    .clk_i      (CLK),
    .rst_ni     (EOS),
    .req_i      (REQ),
    .take_i     (take),
    .any_pend_o (any_pend),
    .sel_o      (sel)
  );

  assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    retry_d = retry_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FAILED: begin
        if (any_pend) begin
          take    = 1'b1;
          gnt_d   = sel;
          retry_d = '0;
          state_d = ST_MRST;
        end
      end
      ST_MRST:  if (cnt_q == MRST_LAST) state_d = ST_LOCKW;
      ST_LOCKW: begin
        // Lock is checked first so it wins over a timeout in the same cycle.
        if (MMCM_LOCK) state_d = ST_SHOLD;
        else if (cnt_q == LOCK_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_MRST;
        end
      end
      ST_SHOLD: begin
        if (!MMCM_LOCK) state_d = ST_MRST;
        else if (cnt_q == HOLD_LAST) state_d = ST_ARST;
      end
      ST_ARST:  state_d = MMCM_LOCK ? ST_AWAIT : ST_MRST;
      ST_AWAIT: begin
        if (!MMCM_LOCK) state_d = ST_MRST;
        else if (ADC_RDY) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end else if (cnt_q == ADC_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAILED : ST_ARST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cnt_d = (state_d != state_q || state_q == ST_IDLE || state_q == ST_FAILED)
               ? '0 : cnt_q + 1'b1;

  always_ff @(posedge CLK or negedge EOS) begin
    if (!EOS) begin
      state_q    <= ST_MRST;
      cnt_q      <= '0;
      gnt_q      <= '0;
      retry_q    <= '0;
      mmcm_rst_q <= 1'b1;
      sys_rst_q  <= 1'b1;
      adc_rst_q  <= 1'b1;
      busy_q     <= 1'b1;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      retry_q    <= retry_d;
      mmcm_rst_q <= (state_d == ST_MRST);
      sys_rst_q  <= (state_d inside {ST_MRST, ST_LOCKW, ST_SHOLD, ST_FAILED});
      adc_rst_q  <= !(state_d inside {ST_AWAIT, ST_IDLE});
      busy_q     <= (state_d != ST_IDLE);
      fail_q     <= (state_d == ST_FAILED);
    end
  end

  assign MMCM_RST     = mmcm_rst_q;
  assign SYS_RST      = sys_rst_q;
  assign ADC_INIT_RST = adc_rst_q;
  assign BUSY         = busy_q;
  assign GNT          = gnt_q;
  assign RETRY_CNT    = retry_q;
  assign FAIL         = fail_q;
  assign SEQ_STATE    = state_q;

endmodule

// File: tb/tb_reset_seq_ctrl.sv
// Directed bench for reset_seq_ctrl with a grant scoreboard; short timeouts keep runs brief.
module tb_reset_seq_ctrl;

  logic       CLK = 1'b0;
  logic       EOS = 1'b1;
  logic [3:0] REQ = 4'b0;
  logic       MMCM_LOCK = 1'b0;
  logic       ADC_RDY = 1'b0;
  logic       MMCM_RST, SYS_RST, ADC_INIT_RST, BUSY, FAIL;
  logic [3:0] GNT;
  logic [1:0] RETRY_CNT;
  logic [2:0] SEQ_STATE;

  int n_assert = 0;
  int n_fail   = 0;
  logic [3:0] exp_q[$];

  always #5 CLK = ~CLK;

  reset_seq_ctrl #(
    .MMCM_RST_CYC(8), .LOCK_TMO(40), .SYS_HOLD(32), .ADC_TMO(60), .MAX_RETRY(3)
  ) dut (
    .CLK(CLK), .EOS(EOS), .REQ(REQ), .MMCM_LOCK(MMCM_LOCK), .ADC_RDY(ADC_RDY),
    .MMCM_RST(MMCM_RST), .SYS_RST(SYS_RST), .ADC_INIT_RST(ADC_INIT_RST), .BUSY(BUSY),
    .GNT(GNT), .RETRY_CNT(RETRY_CNT), .FAIL(FAIL), .SEQ_STATE(SEQ_STATE)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_mmcm"}, MMCM_RST, 1);
    check({tag, "_sys"},  SYS_RST, 1);
    check({tag, "_adc"},  ADC_INIT_RST, 1);
    check({tag, "_busy"}, BUSY, 1);
    check({tag, "_gnt"},  GNT, 0);
    check({tag, "_rty"},  RETRY_CNT, 0);
    check({tag, "_fail"}, FAIL, 0);
    check({tag, "_st"},   SEQ_STATE, 1);
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag, input int budget);
    int k = 0;
    while (SEQ_STATE !== s && k < budget) begin
      tick();
      k++;
    end
    check(tag, SEQ_STATE, s);
  endtask

  // Waits for a new grant to appear on GNT and compares it with the scoreboard head.
  task automatic pop_grant(input logic [3:0] prev, input string tag);
    int k = 0;
    logic [3:0] e;
    while ((GNT === prev || GNT === 4'b0) && k < 300) begin
      tick();
      k++;
    end
    check({tag, "_tmo"}, (k < 300), 1);
    check({tag, "_sb"}, (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, GNT, e);
    end
  endtask

  initial begin
    int mmcm_cnt, shold_cnt, gnt_nz, pulses, lockw_cnt, retry_seq, n, grants;
    logic prev_m;
    logic [1:0] prev_r;
    logic [3:0] prev_g, first_g, e;

    // Asynchronous reset, checked before any clock edge.
    #1 EOS = 1'b0;
    #2 check_reset_vals("rst");

    // Power-up sequence.
    tick();
    EOS = 1'b1;
    mmcm_cnt = 0; shold_cnt = 0; gnt_nz = 0;
    for (int c = 0; c < 120; c++) begin
      if (c == 20)  MMCM_LOCK = 1'b1;
      if (c == 100) ADC_RDY = 1'b1;
      if (MMCM_RST) mmcm_cnt++;
      if (SEQ_STATE == 3'd3 && SYS_RST) shold_cnt++;
      if (GNT != 4'b0) gnt_nz++;
      tick();
    end
    check("pu_mmcm_cycles", mmcm_cnt, 8);
    check("pu_shold_cycles", shold_cnt, 32);
    check("pu_gnt_zero", gnt_nz, 0);
    check("pu_busy", BUSY, 0);
    check("pu_sysrst", SYS_RST, 0);
    check("pu_adcrst", ADC_INIT_RST, 0);

    // Priority and request latency.
    REQ = 4'b1010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    tick();
    check("lat_k_gnt", GNT, 0);
    tick();
    check("lat_k1_gnt", GNT, 4'b0010);
    check("lat_k1_mmcm", MMCM_RST, 1);
    pop_grant(4'b0, "prio1");
    wait_state(3'd0, "prio_idle1", 200);
    check("prio_idle_gnt", GNT, 0);
    pop_grant(4'b0, "prio2");
    wait_state(3'd0, "prio_idle2", 200);
    REQ = 4'b0;
    tick();

    // Lock timeout ending in FAILED, then recovery by a new request.
    MMCM_LOCK = 1'b0;
    ADC_RDY = 1'b0;
    REQ = 4'b0100;
    exp_q.push_back(4'b0100);
    pop_grant(4'b0, "tmo_gnt");
    pulses = MMCM_RST ? 1 : 0;
    prev_m = MMCM_RST;
    prev_r = RETRY_CNT;
    lockw_cnt = 0; retry_seq = 0; n = 0;
    while (FAIL !== 1'b1 && n < 500) begin
      if (SEQ_STATE == 3'd2) lockw_cnt++;
      tick();
      n++;
      if (MMCM_RST && !prev_m) pulses++;
      if (RETRY_CNT != prev_r) retry_seq = retry_seq * 10 + int'(RETRY_CNT);
      prev_m = MMCM_RST;
      prev_r = RETRY_CNT;
    end
    check("tmo_pulses", pulses, 3);
    check("tmo_lockw_cycles", lockw_cnt, 120);
    check("tmo_retry_seq", retry_seq, 123);
    check("tmo_fail", FAIL, 1);
    check("tmo_sysrst", SYS_RST, 1);
    check("tmo_state", SEQ_STATE, 6);
    check("tmo_retry", RETRY_CNT, 3);
    check("tmo_mmcm", MMCM_RST, 0);
    for (int i = 0; i < 5; i++) tick();
    check("fail_hold", FAIL, 1);
    check("fail_hold_st", SEQ_STATE, 6);
    REQ = 4'b0110;
    exp_q.push_back(4'b0010);
    tick();
    check("refail_k", FAIL, 1);
    tick();
    check("refail_clr", FAIL, 0);
    check("refail_rty", RETRY_CNT, 0);
    check("refail_mmcm", MMCM_RST, 1);
    pop_grant(4'b0100, "refail_gnt");
    MMCM_LOCK = 1'b1;
    ADC_RDY = 1'b1;
    wait_state(3'd0, "refail_idle", 200);
    REQ = 4'b0;
    tick();

    // ADC timeout retries into ARST, then lock loss in AWAIT.
    ADC_RDY = 1'b0;
    REQ = 4'b1000;
    exp_q.push_back(4'b1000);
    pop_grant(4'b0, "adc_gnt");
    wait_state(3'd5, "adc_await", 200);
    n = 0;
    while (SEQ_STATE === 3'd5 && n < 200) begin
      n++;
      tick();
    end
    check("adc_await_cycles", n, 60);
    check("adc_retry_state", SEQ_STATE, 4);
    check("adc_retry_cnt", RETRY_CNT, 1);
    wait_state(3'd5, "adc_await2", 10);
    MMCM_LOCK = 1'b0;
    tick();
    check("loss_state", SEQ_STATE, 1);
    check("loss_retry", RETRY_CNT, 1);
    check("loss_mmcm", MMCM_RST, 1);
    MMCM_LOCK = 1'b1;
    ADC_RDY = 1'b1;
    wait_state(3'd0, "loss_idle", 300);
    REQ = 4'b0;
    tick();

    // A held request level produces a single sequence.
    REQ = 4'b0001;
    exp_q.push_back(4'b0001);
    grants = 0; prev_g = GNT; first_g = 4'b0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (GNT != 4'b0 && prev_g == 4'b0) begin
        grants++;
        if (grants == 1) first_g = GNT;
      end
      prev_g = GNT;
    end
    check("held_grants", grants, 1);
    check("held_sb", (exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("held_gnt", first_g, e);
    end
    check("held_busy", BUSY, 0);
    REQ = 4'b0;
    tick();

    // Reset pulsed mid-sequence with a pending request outstanding.
    ADC_RDY = 1'b0;
    REQ = 4'b0001;
    exp_q.push_back(4'b0001);
    pop_grant(4'b0, "mid_gnt");
    wait_state(3'd5, "mid_await", 200);
    REQ = 4'b0011;
    tick();
    #2 EOS = 1'b0;
    #1 check_reset_vals("mid_rst");
    REQ = 4'b0;
    tick();
    EOS = 1'b1;
    ADC_RDY = 1'b1;
    wait_state(3'd0, "mid_pu_idle", 200);
    gnt_nz = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (GNT != 4'b0 || BUSY) gnt_nz++;
    end
    check("mid_pend_cleared", gnt_nz, 0);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
